// File: rtl/bcd_defs.sv
// rtl/bcd_defs.sv - shared state encodings and digit-adjust constants for the BCD converter
package bcd_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one-digit double-dabble correction: add 3 when the digit is 5 or more
module bcd_digit_adj
  import bcd_defs::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Sum truncates to 4 bits; no carry into the next digit.
  assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - iterative binary-to-BCD converter, one bit per clock, with overflow flag
module seq_bin_to_bcd
  import bcd_defs::*;
#(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2,
  parameter int CNT_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BIN_W-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic                            overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q - CNT_W'(1);
        // A set top bit after adjust would shift out of the last digit.
        ovf_d     = ovf_q | adj[BCD_W-1];
        if (cnt_q == CNT_W'(1)) begin
          // Results load on entry to DONE so they are valid alongside done.
          bcd_d      = scratch_d;
          overflow_d = ovf_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
